// File: rtl/mem_stage.sv
// Memory-access stage: takes one instruction from execute, performs its load/store on the
// data-memory port, aligns/extends load data and registers the result at the MEM/WB boundary.
module mem_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   instr_i,
    input  logic [XLEN-1:0]   alures_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wmask_o,
    input  logic              mem_resp_valid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              wb_valid_o,
    output logic [XLEN-1:0]   wb_pc_o,
    output logic [XLEN-1:0]   wb_instr_o,
    output logic [XLEN-1:0]   wb_alures_o,
    output logic [XLEN-1:0]   wb_lsres_o,
    output logic              misalign_o,
    output logic [1:0]        dbg_state
);
    // Handshakes: an instruction transfers on a clock edge where in_valid_i && in_ready_o;
    // a memory request transfers where mem_req_valid_o && mem_req_ready_i, and the request
    // fields stay stable until then; mem_resp_valid_i is a one-cycle strobe honoured only in WAIT.
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc_q, instr_q, alures_q, lsres_q;
    logic [1:0]        size_q;
    logic              uns_q, mis_q, is_load_q;
    logic [OFF_W-1:0]  off_q;

    logic [4:0]        opcode;
    logic [2:0]        funct3;
    logic              is_load, is_store, is_mis;
    logic [OFF_W-1:0]  off, align_m;
    logic [NB-1:0]     lane_ones;
    logic [XLEN-1:0]   ld_shift, ld_val;

    assign dbg_state = state;

    always_comb begin
        opcode    = instr_i[6:2];
        funct3    = instr_i[14:12];
        is_load   = (opcode == 5'b00000);
        is_store  = (opcode == 5'b01000);
        off       = alures_i[OFF_W-1:0];
        align_m   = OFF_W'((32'd1 << funct3[1:0]) - 32'd1);
        lane_ones = NB'((64'd1 << (32'd1 << funct3[1:0])) - 64'd1);
        is_mis    = (is_load | is_store) && ((off & align_m) != '0);
    end

    // Bring the addressed bytes down to bit 0, then extend to the full width.
    always_comb begin
        ld_shift = mem_rdata_i >> {off_q, 3'b000};
        ld_val   = ld_shift;
        case (size_q)
            2'd0:    ld_val = {{(XLEN-8){~uns_q & ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    ld_val = {{(XLEN-16){~uns_q & ld_shift[15]}}, ld_shift[15:0]};
            2'd2:    ld_val = {{(XLEN-32){~uns_q & ld_shift[31]}}, ld_shift[31:0]};
            default: ld_val = ld_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            in_ready_o      <= 1'b1;
            mem_req_valid_o <= 1'b0;
            mem_wen_o       <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
            mem_wmask_o     <= '0;
            wb_valid_o      <= 1'b0;
            wb_pc_o         <= '0;
            wb_instr_o      <= '0;
            wb_alures_o     <= '0;
            wb_lsres_o      <= '0;
            misalign_o      <= 1'b0;
            pc_q            <= '0;
            instr_q         <= '0;
            alures_q        <= '0;
            lsres_q         <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            mis_q           <= 1'b0;
            is_load_q       <= 1'b0;
            off_q           <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        in_ready_o <= 1'b0;
                        pc_q       <= pc_i;
                        instr_q    <= instr_i;
                        alures_q   <= alures_i;
                        lsres_q    <= '0;
                        size_q     <= funct3[1:0];
                        uns_q      <= funct3[2];
                        mis_q      <= is_mis;
                        is_load_q  <= is_load;
                        off_q      <= off;
                        if ((is_load || is_store) && !is_mis) begin
                            state           <= REQ;
                            mem_req_valid_o <= 1'b1;
                            mem_wen_o       <= is_store;
                            mem_addr_o      <= {alures_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata_o     <= is_store ? (rs2_data_i << {off, 3'b000}) : '0;
                            mem_wmask_o     <= is_store ? (lane_ones << off) : '0;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        // Ready returns one cycle after the writeback pulse.
                        in_ready_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        state           <= WAIT;
                        mem_req_valid_o <= 1'b0;
                        mem_wen_o       <= 1'b0;
                        mem_wdata_o     <= '0;
                        mem_wmask_o     <= '0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid_i) begin
                        state <= DONE;
                        if (is_load_q) begin
                            lsres_q <= ld_val;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    wb_valid_o  <= 1'b1;
                    wb_pc_o     <= pc_q;
                    wb_instr_o  <= instr_q;
                    wb_alures_o <= alures_q;
                    wb_lsres_o  <= lsres_q;
                    misalign_o  <= mis_q;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a spec-level model fills an expected-retirement queue that is
// checked on every writeback pulse, alongside literal values for the documented examples.
module tb_mem_stage;
    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;
    localparam int W      = 4 * XLEN + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid_i, in_ready_o;
    logic [XLEN-1:0]   pc_i, instr_i, alures_i, rs2_data_i;
    logic              mem_req_valid_o, mem_req_ready_i, mem_wen_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic [XLEN/8-1:0] mem_wmask_o;
    logic              mem_resp_valid_i;
    logic [XLEN-1:0]   mem_rdata_i;
    logic              wb_valid_o;
    logic [XLEN-1:0]   wb_pc_o, wb_instr_o, wb_alures_o, wb_lsres_o;
    logic              misalign_o;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];

    mem_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .alures_i(alures_i), .rs2_data_i(rs2_data_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o), .wb_pc_o(wb_pc_o),
        .wb_instr_o(wb_instr_o), .wb_alures_o(wb_alures_o), .wb_lsres_o(wb_lsres_o),
        .misalign_o(misalign_o), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- spec-level model ----------------
    function automatic logic [63:0] mk(input logic [6:0] opc, input logic [2:0] f3);
        return {32'd0, 17'd0, f3, 5'd1, opc};
    endfunction

    function automatic int nbytes(input logic [63:0] instr);
        return 1 << instr[13:12];
    endfunction

    function automatic bit is_ld(input logic [63:0] instr);
        return instr[6:2] == 5'b00000;
    endfunction

    function automatic bit is_st(input logic [63:0] instr);
        return instr[6:2] == 5'b01000;
    endfunction

    function automatic bit model_mis(input logic [63:0] instr, input logic [63:0] addr);
        int off;
        off = int'(addr[2:0]);
        return (is_ld(instr) || is_st(instr)) && (off % nbytes(instr) != 0);
    endfunction

    function automatic logic [63:0] model_lsres(input logic [63:0] instr, input logic [63:0] addr,
                                                input logic [63:0] rdata);
        int nb, off;
        logic [63:0] v;
        if (!is_ld(instr) || model_mis(instr, addr)) return 64'd0;
        nb  = nbytes(instr);
        off = int'(addr[2:0]);
        v   = 64'd0;
        for (int i = 0; i < nb; i++)
            v = v + (((rdata >> (8 * (off + i))) & 64'hFF) << (8 * i));
        if (!instr[14] && nb < 8 && v >= (64'd1 << (8 * nb - 1)))
            v = v - (64'd1 << (8 * nb));
        return v;
    endfunction

    function automatic logic [7:0] model_mask(input logic [63:0] instr, input logic [63:0] addr);
        logic [7:0] m;
        m = 8'd0;
        if (is_st(instr))
            for (int i = 0; i < nbytes(instr); i++) m[int'(addr[2:0]) + i] = 1'b1;
        return m;
    endfunction

    // ---------------- scoreboard: every writeback pulse ----------------
    always @(negedge clk) begin : compare
        logic [W-1:0] e;
        if (rst_n) begin
            if (wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected actual=pulse pc=%h required=no pulse", wb_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_pc", wb_pc_o, e[256:193]);
                    chk("wb_instr", wb_instr_o, e[192:129]);
                    chk("wb_alures", wb_alures_o, e[128:65]);
                    chk("wb_lsres", wb_lsres_o, e[64:1]);
                    chk("wb_misalign", 64'(misalign_o), 64'(e[0]));
                end
            end else begin
                chk("misalign_without_wb", 64'(misalign_o), 64'd0);
            end
        end
    end

    // ---------------- driver / memory responder ----------------
    task automatic run_op(input logic [63:0] pc, input logic [63:0] instr,
                          input logic [63:0] addr, input logic [63:0] rs2,
                          input logic [63:0] rdata, input int rdy_stall, input int resp_stall,
                          input bit hold_rdy, input bit stray,
                          output int lat, output int wb_cyc, output logic [63:0] cap_wdata,
                          output logic [7:0] cap_mask, output logic cap_wen,
                          output logic [31:0] cap_addr);
        int n, reqs, wcnt;
        bit granted, mis, mem_op;
        mis    = model_mis(instr, addr);
        mem_op = (is_ld(instr) || is_st(instr)) && !mis;
        lat = 0; wb_cyc = 0; reqs = 0; wcnt = 0; granted = 0;
        cap_wdata = '0; cap_mask = '0; cap_wen = 1'b0; cap_addr = '0;
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_issue", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b1; pc_i = pc; instr_i = instr; alures_i = addr; rs2_data_i = rs2;
        mem_req_ready_i = hold_rdy;
        @(posedge clk);
        exp_q.push_back({pc, instr, addr, model_lsres(instr, addr, rdata), mis});
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            // Keep a different instruction on the input bus while busy; it must be ignored.
            pc_i = ~pc; instr_i = mk(7'h13, 3'd0); alures_i = 64'hFFFF;
            mem_resp_valid_i = 1'b0; mem_req_ready_i = hold_rdy; mem_rdata_i = 64'hA5A5_A5A5_A5A5_A5A5;
            if (wb_valid_o) begin
                lat = n;
                wb_cyc = cyc;
                break;
            end
            if (mem_req_valid_o) begin
                reqs++;
                if (reqs == 1) begin
                    cap_wdata = mem_wdata_o; cap_mask = mem_wmask_o;
                    cap_wen = mem_wen_o; cap_addr = mem_addr_o;
                end
                if (reqs > rdy_stall) begin
                    mem_req_ready_i = 1'b1;
                    granted = 1'b1;
                end else if (stray) begin
                    mem_resp_valid_i = 1'b1;
                end
            end else if (granted) begin
                wcnt++;
                if (wcnt > resp_stall) begin
                    mem_resp_valid_i = 1'b1;
                    mem_rdata_i = rdata;
                    granted = 1'b0;
                end
            end
        end
        in_valid_i = 1'b0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_timeout actual=no pulse in 60 cycles required=pulse pc=%h", pc);
        end
        chk("latency", 64'(lat), mem_op ? 64'(4 + rdy_stall + resp_stall) : 64'd2);
        chk("req_cycles", 64'(reqs), mem_op ? 64'(rdy_stall + 1) : 64'd0);
        if (mem_op) begin
            chk("req_addr", 64'(cap_addr), {32'd0, addr[31:0] - 32'(addr[2:0])});
            chk("req_wen", 64'(cap_wen), 64'(is_st(instr)));
            chk("req_wmask", 64'(cap_mask), 64'(model_mask(instr, addr)));
            chk("req_wdata", cap_wdata, is_st(instr) ? (rs2 << (8 * int'(addr[2:0]))) : 64'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int lat, wbc, prev_wbc;
        logic [63:0] cw;
        logic [7:0] cm;
        logic cwen;
        logic [31:0] ca;
        logic [63:0] LB, LH, LW, LD, LHU, LWU, SB, SH, SW, SD, ADDI;
        LB = mk(7'h03, 3'd0); LH = mk(7'h03, 3'd1); LW = mk(7'h03, 3'd2); LD = mk(7'h03, 3'd3);
        LHU = mk(7'h03, 3'd5); LWU = mk(7'h03, 3'd6);
        SB = mk(7'h23, 3'd0); SH = mk(7'h23, 3'd1); SW = mk(7'h23, 3'd2); SD = mk(7'h23, 3'd3);
        ADDI = mk(7'h13, 3'd0);

        rst_n = 1'b0; in_valid_i = 1'b0; pc_i = '0; instr_i = '0; alures_i = '0; rs2_data_i = '0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_wmask", 64'(mem_wmask_o), 64'd0);
        chk("rst_wb_lsres", wb_lsres_o, 64'd0);
        chk("rst_wb_pc", wb_pc_o, 64'd0);
        chk("rst_misalign", 64'(misalign_o), 64'd0);
        rst_n = 1'b1;

        // Model pinned to the documented examples.
        chk("model_lb", model_lsres(LB, 64'h8000_0003, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
        chk("model_lhu", model_lsres(LHU, 64'h8000_0006, 64'hBEEF_0000_0000_0000), 64'h0000_0000_0000_BEEF);
        chk("model_sw_mask", 64'(model_mask(SW, 64'h8000_0004)), 64'hF0);

        // A response with no transaction open must be ignored.
        @(negedge clk); mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h1111;
        @(negedge clk); mem_resp_valid_i = 1'b0;

        run_op(64'h1000, LB, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, 0, lat, wbc, cw, cm, cwen, ca);
        chk("lb_lsres_lit", wb_lsres_o, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_addr_lit", 64'(ca), 64'h8000_0000);

        run_op(64'h1004, LHU, 64'h8000_0006, 64'd0, 64'hBEEF_0000_0000_0000, 1, 0, 0, 1, lat, wbc, cw, cm, cwen, ca);
        chk("lhu_lsres_lit", wb_lsres_o, 64'h0000_0000_0000_BEEF);

        run_op(64'h1008, SW, 64'h8000_0004, 64'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, lat, wbc, cw, cm, cwen, ca);
        chk("sw_wmask_lit", 64'(cm), 64'hF0);
        chk("sw_wdata_lit", cw, 64'h1234_5678_0000_0000);
        chk("sw_wen_lit", 64'(cwen), 64'd1);
        chk("sw_lsres_lit", wb_lsres_o, 64'd0);

        run_op(64'h100C, LD, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 3, 2, 0, 1, lat, wbc, cw, cm, cwen, ca);
        chk("ld_latency_lit", 64'(lat), 64'd9);
        chk("ld_lsres_lit", wb_lsres_o, 64'h0123_4567_89AB_CDEF);

        prev_wbc = 0;
        for (int i = 0; i < 3; i++) begin
            run_op(64'h2000 + 64'(4 * i), ADDI, 64'(100 + i), 64'd7, 64'd0, 0, 0, 0, 0, lat, wbc, cw, cm, cwen, ca);
            chk("addi_lsres_lit", wb_lsres_o, 64'd0);
            if (i > 0) chk("addi_pulse_spacing", 64'(wbc - prev_wbc), 64'd3);
            prev_wbc = wbc;
        end

        run_op(64'h3000, LW, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, lat, wbc, cw, cm, cwen, ca);
        chk("lw_mis_lsres_lit", wb_lsres_o, 64'd0);

        run_op(64'h3004, SB, 64'h8000_0005, 64'hCAFE_F00D_DEAD_BEAB, 64'd0, 0, 1, 1, 0, lat, wbc, cw, cm, cwen, ca);
        chk("sb_wmask_lit", 64'(cm), 64'h20);

        run_op(64'h3008, LH, 64'h8000_000A, 64'd0, 64'h0000_0000_8001_0000, 2, 0, 0, 0, lat, wbc, cw, cm, cwen, ca);
        chk("lh_lsres_lit", wb_lsres_o, 64'hFFFF_FFFF_FFFF_8001);

        run_op(64'h300C, LWU, 64'h8000_0004, 64'd0, 64'h9000_0001_7777_7777, 0, 1, 0, 0, lat, wbc, cw, cm, cwen, ca);
        chk("lwu_lsres_lit", wb_lsres_o, 64'h0000_0000_9000_0001);

        run_op(64'h3010, SD, 64'h8000_0018, 64'h0102_0304_0506_0708, 64'd0, 1, 1, 0, 0, lat, wbc, cw, cm, cwen, ca);
        chk("sd_wmask_lit", 64'(cm), 64'hFF);
        run_op(64'h3014, SH, 64'h8000_0003, 64'hFFFF, 64'd0, 0, 0, 0, 0, lat, wbc, cw, cm, cwen, ca);

        // Reset while waiting for a load response: abandon it, ignore the late response.
        @(negedge clk);
        in_valid_i = 1'b1; pc_i = 64'h4000; instr_i = LD; alures_i = 64'h8000_0040;
        @(posedge clk);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("rstwait_req_valid", 64'(mem_req_valid_o), 64'd1);
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        chk("rstwait_in_wait", 64'(mem_req_valid_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstwait_in_ready", 64'(in_ready_o), 64'd1);
        chk("rstwait_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rstwait_wb_pc", wb_pc_o, 64'd0);
        mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h5555_5555_5555_5555;
        @(negedge clk);
        mem_resp_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rstwait_no_wb", 64'(wb_valid_o), 64'd0);
            @(negedge clk);
        end

        run_op(64'h5000, LW, 64'h8000_0000, 64'd0, 64'h1234_5678_FFFF_FFFE, 0, 0, 0, 0, lat, wbc, cw, cm, cwen, ca);
        chk("post_rst_lw_lit", wb_lsres_o, 64'hFFFF_FFFF_FFFF_FFFE);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
